// File: rtl/elc3_trace_pkg.sv
// Shared types for the register-write trace buffer.
// The entry layout depends on module parameters, so each user declares it from these widths.
package elc3_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam int TRACE_DEF_WIDTH = 16;
  localparam int TRACE_DEF_AW    = 3;

  function automatic int entry_width(input int aw, input int width);
    return aw + width;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port and one registered read port.
// The memory array is not reset; only the read register is cleared.
module trace_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 19,
  parameter int PW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [PW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [PW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/reg_trace_buffer.sv
// Captures register-file writes into a trace FIFO after an optional trigger write,
// then lets software pop the captured {addr, data} entries oldest first.
module reg_trace_buffer
  import elc3_trace_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int DEPTH    = 16,
  parameter int WRAP     = 0,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Arm,
  input  logic             Stop,
  input  logic             Trig_En,
  input  logic [AW-1:0]    Trig_Addr,
  input  logic             Wr_En,
  input  logic [AW-1:0]    Wr_Addr,
  input  logic [WIDTH-1:0] Wr_Data,
  input  logic             Rd_Req,
  output logic             Rd_Valid,
  output logic [AW-1:0]    Rd_Addr,
  output logic [WIDTH-1:0] Rd_Data,
  output logic [CW-1:0]    Count,
  output logic             Overflow,
  output logic [1:0]       State
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = entry_width(AW, WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } trace_entry_t;

  trace_state_t  state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          rd_vld_p1;
  logic          full, capture, pop;
  trace_entry_t  wr_entry, rd_entry_p1;

  // Arm and Stop both suppress a coincident write; Arm also blocks a pop.
  always_comb begin
    full     = (count == FULL_CNT);
    capture  = Wr_En && !Arm && !Stop && (!full || (WRAP != 0)) &&
               ((state == ST_CAPTURE) || ((state == ST_ARMED) && (Wr_Addr == Trig_Addr)));
    pop      = Rd_Req && !Arm && (state == ST_DONE) && (count != '0);
    wr_entry = '{addr: Wr_Addr, data: Wr_Data};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= pop;
      if (Arm) begin
        state    <= Trig_En ? ST_ARMED : ST_CAPTURE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (capture) begin
          wr_ptr <= wr_ptr + 1'b1;
          // A write into a full wrapping buffer displaces the oldest entry.
          if (full) begin
            rd_ptr   <= rd_ptr + 1'b1;
            overflow <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        case (state)
          ST_ARMED: begin
            if (Stop)         state <= ST_DONE;
            else if (capture) state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (Stop) state <= ST_DONE;
            else if (capture && (WRAP == 0) && (count == LAST_CNT)) state <= ST_DONE;
          end
          default: state <= state;
        endcase
      end
    end
  end

  // Read stage p1: RAM output register carries the popped entry.
  trace_ram #(
    .DEPTH  (DEPTH),
    .ENTRY_W(EW),
    .PW     (PW)
  ) u_ram (
    .clk  (Clk),
    .rst  (Reset),
    .we   (capture),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .re   (pop),
    .raddr(rd_ptr),
    .rdata(rd_entry_p1)
  );

  assign Rd_Valid = rd_vld_p1;
  assign Rd_Addr  = rd_entry_p1.addr;
  assign Rd_Data  = rd_entry_p1.data;
  assign Count    = count;
  assign Overflow = overflow;
  assign State    = state;

endmodule
